// File: rtl/return_addr_stack.sv
// Circular return-address stack: pushes link addresses on calls and hands them back in LIFO order.
// When the stack is full, a push overwrites the oldest entry and the stack keeps working.
module return_addr_stack #(
    parameter int unsigned SIZE  = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [SIZE-1:0]  push_addr,
    input  logic             pop,
    output logic [SIZE-1:0]  top_addr,
    output logic             top_valid,
    output logic             full,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(DEPTH);

    logic [SIZE-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             we;
    logic [PTR_W-1:0] waddr;
    logic             empty;

    assign empty = (count_q == '0);

    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        we          = 1'b0;
        waddr       = tos_q;
        if (flush) begin
            tos_d   = '0;
            count_d = '0;
        end else if (push && pop && !empty) begin
            // Call and return in the same cycle: replace the top in place.
            we = 1'b1;
        end else if (push) begin
            tos_d = tos_q + PTR_W'(1);
            waddr = tos_q + PTR_W'(1);
            we    = 1'b1;
            if (count_q == DepthCnt) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + (PTR_W + 1)'(1);
            end
            underflow_d = pop;
        end else if (pop) begin
            if (empty) begin
                underflow_d = 1'b1;
            end else begin
                tos_d   = tos_q - PTR_W'(1);
                count_d = count_q - (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && we) begin
            mem[waddr] <= push_addr;
        end
    end

    assign top_addr  = empty ? '0 : mem[tos_q];
    assign top_valid = !empty;
    assign full      = (count_q == DepthCnt);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack with hand-computed expectations.
module tb_return_addr_stack;

    logic        clk = 1'b0;
    logic        rst, flush, push, pop;
    logic [31:0] push_addr;
    logic [31:0] top_addr;
    logic        top_valid, full, overflow, underflow;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    return_addr_stack #(.SIZE(32), .DEPTH(8), .PTR_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .top_addr  (top_addr),
        .top_valid (top_valid),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, then sample 1ns after the edge.
    task automatic cyc(input logic r, input logic f, input logic p, input logic [31:0] a,
                       input logic po);
        rst = r; flush = f; push = p; push_addr = a; pop = po;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; push = 1'b0; push_addr = '0; pop = 1'b0;
    endtask

    task automatic status(input string tag, input int c, input logic [31:0] t,
                          input logic ov, input logic un);
        check({tag, " count"}, 32'(count), 32'(c));
        check({tag, " top_addr"}, top_addr, t);
        check({tag, " top_valid"}, 32'(top_valid), 32'(c != 0));
        check({tag, " full"}, 32'(full), 32'(c == 8));
        check({tag, " overflow"}, 32'(overflow), 32'(ov));
        check({tag, " underflow"}, 32'(underflow), 32'(un));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push = 1'b0; push_addr = '0; pop = 1'b0;
        cyc(1, 0, 0, 0, 0);
        status("reset", 0, 0, 0, 0);

        cyc(0, 0, 1, 32'h100, 0);
        cyc(0, 0, 1, 32'h200, 0);
        cyc(0, 0, 1, 32'h300, 0);
        status("push3", 3, 32'h300, 0, 0);
        cyc(0, 0, 0, 0, 1);
        status("pop1", 2, 32'h200, 0, 0);
        cyc(0, 0, 0, 0, 1);
        status("pop2", 1, 32'h100, 0, 0);
        cyc(0, 0, 0, 0, 1);
        status("pop3", 0, 0, 0, 0);

        for (int i = 1; i <= 8; i++) cyc(0, 0, 1, 32'(i), 0);
        status("fill8", 8, 32'h8, 0, 0);
        cyc(0, 0, 1, 32'h9, 0);
        status("push9", 8, 32'h9, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            cyc(0, 0, 0, 0, 1);
            status("wrap pop", 8 - k, 32'(9 - k), 0, 0);
        end
        cyc(0, 0, 0, 0, 1);
        status("wrap empty", 0, 0, 0, 0);

        cyc(0, 0, 0, 0, 1);
        status("pop empty", 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        status("underflow clear", 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h40, 1);
        status("push+pop empty", 1, 32'h40, 0, 1);
        cyc(0, 0, 0, 0, 1);
        status("drain40", 0, 0, 0, 0);

        cyc(0, 0, 1, 32'hA, 0);
        cyc(0, 0, 1, 32'hB, 0);
        cyc(0, 0, 1, 32'hC, 1);
        status("replace top", 2, 32'hC, 0, 0);
        cyc(0, 0, 0, 0, 1);
        status("after replace", 1, 32'hA, 0, 0);
        cyc(0, 0, 0, 0, 1);

        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'h10 + 32'(i), 0);
        status("fill5", 5, 32'h14, 0, 0);
        cyc(0, 1, 1, 32'h77, 0);
        status("flush", 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h55, 0);
        status("after flush", 1, 32'h55, 0, 0);
        cyc(0, 1, 0, 0, 0);

        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h20 + 32'(i), 0);
        status("fill4", 4, 32'h23, 0, 0);
        cyc(1, 0, 0, 0, 1);
        status("rst+pop", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Hardware return-address stack for the MIPS_32 fetch path.
- Stores link addresses (PC+1 values from the PC incrementer) on call instructions and supplies them back on returns.
- Acts as the reader/consumer end of the incremented-PC path: it buffers addresses the incrementer produced and returns them in LIFO order.
- Circular storage; the oldest entry is silently overwritten when full.

Parameters:
- SIZE, 32, address width in bits
- DEPTH, 8, number of entries (power of two, ≥2)
- PTR_W, 3, pointer width = log2(DEPTH)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all entries (mispredict recovery)
- push  input  1  store push_addr as new top (call)
- push_addr  input  SIZE  link address (PC+1)
- pop  input  1  remove top entry (return)
- top_addr  output  SIZE  current top entry; 0 when empty
- top_valid  output  1  stack non-empty
- full  output  1  count == DEPTH
- count  output  PTR_W+1  number of valid entries, 0..DEPTH
- overflow  output  1  one-cycle pulse: push overwrote the oldest entry
- underflow  output  1  one-cycle pulse: pop requested while empty

Behaviour:
- State: storage array mem[0..DEPTH-1], top pointer tos (PTR_W bits, index of current top), count.
- Reset (rst=1 at clk edge): tos=0, count=0, overflow=0, underflow=0; top_addr=0, top_valid=0, full=0. Storage contents need not be cleared.
- top_addr = mem[tos] when count>0, else 0. Read is combinational from registered state; a push is visible on top_addr the cycle after the push edge.
- top_valid = (count != 0); full = (count == DEPTH).
- overflow and underflow are registered, asserted for exactly the cycle after the triggering edge, and otherwise 0.
- Priority per edge: rst > flush > push/pop combination.
- flush=1: count=0 and tos=0; push/pop ignored that cycle; no overflow/underflow pulse.
- push only, count<DEPTH: tos=tos+1 mod DEPTH, mem[new tos]=push_addr, count+1.
- push only, count==DEPTH:
  - tos wraps (+1 mod DEPTH) and the write replaces the oldest entry.
  - count stays at DEPTH; overflow pulses.
- pop only, count>0: tos=tos-1 mod DEPTH, count-1. Storage is unchanged.
- pop only, count==0: no state change; underflow pulses.
- push and pop together, count>0: mem[tos]=push_addr (top replaced). tos and count unchanged; no pulse.
- push and pop together, count==0: treated as push only (count becomes 1); underflow pulses.
- Pointer arithmetic is modulo DEPTH; wrap is natural PTR_W-bit rollover in both directions.
- A pop after wrap-around returns entries newest-first. After DEPTH pops following an overflow, the stack is empty; overwritten entries are never returned.
- Reset asserted mid-sequence takes effect on that edge regardless of push/pop/flush.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 on consecutive cycles -> count=3, top_addr=0x300; then pop ×3 -> top_addr 0x200, 0x100, 0 with top_valid=0, no underflow.
- Push 9 values 0x1..0x9 (DEPTH=8) -> overflow pulses one cycle after 9th push, full=1, count=8, top_addr=0x9; pop ×8 -> tops 0x8..0x2 then empty; 0x1 never appears.
- Pop when empty -> underflow=1 for exactly one cycle, count stays 0, top_addr=0; simultaneous push 0x40+pop when empty -> count=1, top_addr=0x40, underflow pulse.
- With stack holding 0xA,0xB: push 0xC with pop same cycle -> count=2, top_addr=0xC; pop -> top_addr=0xA.
- Fill 5 entries, assert flush together with push 0x77 -> count=0, top_valid=0, no pulses; a subsequent push of 0x55 -> top_addr=0x55, count=1.
- Fill 4 entries, assert rst with pop -> next cycle count=0, full=0, overflow=underflow=0, top_addr=0.
